// File: rtl/seg7_pkg.sv
// Shared widths and seven-segment patterns for the BCD display path.
// Patterns are active-low with segment A in bit 0 through segment G in bit 6.
package seg7_pkg;

   localparam int BCD_W = 4;
   localparam int SEG_W = 7;

   localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Codes 10-15 never occur in a healthy counter; they show as a dark digit.
   function automatic logic [SEG_W-1:0] seg_decode(input logic [BCD_W-1:0] bcd);
      logic [SEG_W-1:0] seg;
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_DIGIT[0];
         4'd1:    seg = SEG_DIGIT[1];
         4'd2:    seg = SEG_DIGIT[2];
         4'd3:    seg = SEG_DIGIT[3];
         4'd4:    seg = SEG_DIGIT[4];
         4'd5:    seg = SEG_DIGIT[5];
         4'd6:    seg = SEG_DIGIT[6];
         4'd7:    seg = SEG_DIGIT[7];
         4'd8:    seg = SEG_DIGIT[8];
         4'd9:    seg = SEG_DIGIT[9];
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One registered BCD digit of the up/down counter.
// cin marks that every lower digit is rolling over, so this digit must move too;
// cout tells the next digit up the same thing. freeze holds the digit when the
// whole counter sits at a limit in saturate mode.
module bcd_digit_cell
   import seg7_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             step_up,
   input  logic             step_dn,
   input  logic             cin,
   input  logic             freeze,
   output logic [BCD_W-1:0] digit,
   output logic             cout
);

   assign cout = cin & ((step_up & (digit == 4'd9)) | (step_dn & (digit == 4'd0)));

   // Digit register: clear wins, otherwise move one step when the ripple reaches us.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit <= '0;
      end else if (clear) begin
         digit <= '0;
      end else if (cin && !freeze) begin
         if (step_up) begin
            digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
         end else if (step_dn) begin
            digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_updown_7seg.sv
// N-digit BCD up/down counter with auto-repeat, wrap/saturate limits and
// registered active-low seven-segment outputs.
module bcd_updown_7seg
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 2,
   parameter int REPEAT_DELAY  = 12_500_000,
   parameter int REPEAT_PERIOD = 2_500_000
)(
   input  logic                        i_Clk,
   input  logic                        i_Rst,
   input  logic                        i_Up,
   input  logic                        i_Down,
   input  logic                        i_Clear,
   input  logic                        i_Sat_Mode,
   output logic [BCD_W*NUM_DIGITS-1:0] o_Count,
   output logic [SEG_W*NUM_DIGITS-1:0] o_Segments,
   output logic                        o_Limit
);

   localparam int MAX_RP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W = $clog2(MAX_RP) + 1;
   localparam logic [HOLD_W-1:0] DELAY_CNT  = HOLD_W'(REPEAT_DELAY);
   localparam logic [HOLD_W-1:0] PERIOD_CNT = HOLD_W'(REPEAT_PERIOD);
   localparam logic RPT_EN = (REPEAT_DELAY != 0);

   logic              up_prev;
   logic              down_prev;
   logic              armed;
   logic              repeat_phase;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_target;
   logic              up_edge;
   logic              down_edge;
   logic              one_held;
   logic              rpt_tick;
   logic              up_req;
   logic              down_req;
   logic              up_do;
   logic              down_do;
   logic              boundary;
   logic              freeze;
   logic [NUM_DIGITS:0] carry;
   logic [BCD_W-1:0]  digit_q [NUM_DIGITS];
   logic [SEG_W-1:0]  seg_q   [NUM_DIGITS];

   assign carry[0] = 1'b1;

   // Step requests, priority resolution and limit detection from the carry chain.
   always_comb begin
      up_edge     = i_Up & ~up_prev;
      down_edge   = i_Down & ~down_prev;
      one_held    = i_Up ^ i_Down;
      hold_target = repeat_phase ? PERIOD_CNT : DELAY_CNT;
      rpt_tick    = RPT_EN & armed & one_held & ~(up_edge | down_edge)
                    & (hold_cnt == hold_target);
      up_req      = up_edge | (rpt_tick & i_Up);
      down_req    = down_edge | (rpt_tick & i_Down);
      up_do       = up_req & ~down_req & ~i_Clear;
      down_do     = down_req & ~up_req & ~i_Clear;
      boundary    = carry[NUM_DIGITS];
      freeze      = i_Sat_Mode & boundary;
   end

   // Previous button levels; reset high so a button held through reset is not a press.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         up_prev   <= 1'b1;
         down_prev <= 1'b1;
      end else begin
         up_prev   <= i_Up;
         down_prev <= i_Down;
      end
   end

   // Hold timer: armed only by a real press, counts to the delay, then to the period.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         hold_cnt     <= '0;
         repeat_phase <= 1'b0;
         armed        <= 1'b0;
      end else if (i_Clear || !one_held) begin
         hold_cnt     <= '0;
         repeat_phase <= 1'b0;
         armed        <= 1'b0;
      end else if (up_edge || down_edge) begin
         hold_cnt     <= HOLD_W'(1);
         repeat_phase <= 1'b0;
         armed        <= 1'b1;
      end else if (armed && RPT_EN) begin
         if (rpt_tick) begin
            hold_cnt     <= HOLD_W'(1);
            repeat_phase <= 1'b1;
         end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
         end
      end
   end

   // Limit pulse: a step that ripples out of the top digit hit a boundary.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         o_Limit <= 1'b0;
      end else begin
         o_Limit <= boundary;
      end
   end

   // Registered decoders, one cycle behind the count.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_q[k] <= SEG_DIGIT[0];
         end
      end else begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_q[k] <= seg_decode(digit_q[k]);
         end
      end
   end

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
      bcd_digit_cell u_cell (
         .clk     (i_Clk),
         .rst     (i_Rst),
         .clear   (i_Clear),
         .step_up (up_do),
         .step_dn (down_do),
         .cin     (carry[k]),
         .freeze  (freeze),
         .digit   (digit_q[k]),
         .cout    (carry[k+1])
      );
      assign o_Count[BCD_W*k +: BCD_W]    = digit_q[k];
      assign o_Segments[SEG_W*k +: SEG_W] = seg_q[k];
   end

endmodule

// File: tb/tb_bcd_updown_7seg.sv
// Directed bench for bcd_updown_7seg with NUM_DIGITS=2, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_bcd_updown_7seg;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b0;
   logic        i_Up = 1'b0;
   logic        i_Down = 1'b0;
   logic        i_Clear = 1'b0;
   logic        i_Sat_Mode = 1'b0;
   logic [7:0]  o_Count;
   logic [13:0] o_Segments;
   logic        o_Limit;

   int errorCount = 0;
   int checkCount = 0;
   logic satMode = 1'b0;

   bcd_updown_7seg #(
      .NUM_DIGITS    (2),
      .REPEAT_DELAY  (8),
      .REPEAT_PERIOD (3)
   ) dut (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Up       (i_Up),
      .i_Down     (i_Down),
      .i_Clear    (i_Clear),
      .i_Sat_Mode (i_Sat_Mode),
      .o_Count    (o_Count),
      .o_Segments (o_Segments),
      .o_Limit    (o_Limit)
   );

   always #5 i_Clk = ~i_Clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
   task automatic applyStimulus(input logic up, input logic dn, input logic clr);
      i_Up       = up;
      i_Down     = dn;
      i_Clear    = clr;
      i_Sat_Mode = satMode;
      @(posedge i_Clk);
      #1;
   endtask

   task automatic pulseUp();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulseDown();
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic clearCount();
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int expCount;

      // Reset with i_Up held high: nothing may step after release
      i_Rst = 1'b1;
      i_Up  = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("rst_count", 32'(o_Count), 32'h00);
      checkOutput("rst_segs", 32'(o_Segments), 32'h2040);
      checkOutput("rst_limit", 32'(o_Limit), 32'h0);
      i_Rst = 1'b0;
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("rst_held_count", 32'(o_Count), 32'h00);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Carry: ten single presses
      for (int i = 0; i < 9; i++) pulseUp();
      checkOutput("count_09", 32'(o_Count), 32'h09);
      checkOutput("segs_09", 32'(o_Segments), 32'h2010);
      pulseUp();
      checkOutput("carry_count", 32'(o_Count), 32'h10);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("carry_seg_d1", 32'(o_Segments[13:7]), 32'h79);
      checkOutput("carry_seg_d0", 32'(o_Segments[6:0]), 32'h40);
      pulseDown();
      checkOutput("borrow_count", 32'(o_Count), 32'h09);

      // Wrap mode limits
      clearCount();
      checkOutput("clear_count", 32'(o_Count), 32'h00);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("wrap_dn_count", 32'(o_Count), 32'h99);
      checkOutput("wrap_dn_limit", 32'(o_Limit), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("wrap_dn_limit_off", 32'(o_Limit), 32'h0);
      checkOutput("segs_99", 32'(o_Segments), 32'h0810);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("wrap_up_count", 32'(o_Count), 32'h00);
      checkOutput("wrap_up_limit", 32'(o_Limit), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("wrap_up_limit_off", 32'(o_Limit), 32'h0);

      // Saturate mode limits
      satMode = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sat_dn_count", 32'(o_Count), 32'h00);
      checkOutput("sat_dn_limit", 32'(o_Limit), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("sat_dn_limit_off", 32'(o_Limit), 32'h0);
      satMode = 1'b0;
      pulseDown();
      satMode = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("sat_up_count", 32'(o_Count), 32'h99);
      checkOutput("sat_up_limit", 32'(o_Limit), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("sat_mid_count", 32'(o_Count), 32'h98);
      checkOutput("sat_mid_limit", 32'(o_Limit), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      satMode = 1'b0;

      // Auto-repeat: steps at hold cycles 0, 8, 11, 14, 17
      clearCount();
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         expCount = 1 + int'(k >= 8) + int'(k >= 11) + int'(k >= 14) + int'(k >= 17);
         checkOutput($sformatf("repeat_k%0d", k), 32'(o_Count), 32'(expCount));
      end
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("repeat_release", 32'(o_Count), 32'h05);

      // Simultaneous up and down edges
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("both_count", 32'(o_Count), 32'h05);
      checkOutput("both_limit", 32'(o_Limit), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Clear beats an up edge
      clearCount();
      for (int i = 0; i < 42; i++) pulseUp();
      checkOutput("count_42", 32'(o_Count), 32'h42);
      checkOutput("segs_42", 32'(o_Segments), 32'h0CA4);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("clr_up_count", 32'(o_Count), 32'h00);
      checkOutput("clr_up_limit", 32'(o_Limit), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Clear during a hold: no further repeats until re-pressed
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("hold_clr_first", 32'(o_Count), 32'h01);
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("hold_clr_norepeat", 32'(o_Count), 32'h00);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset in the middle of a hold
      for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("midhold_count", 32'(o_Count), 32'h02);
      i_Rst = 1'b1;
      #1;
      checkOutput("midrst_count", 32'(o_Count), 32'h00);
      checkOutput("midrst_segs", 32'(o_Segments), 32'h2040);
      applyStimulus(1'b1, 1'b0, 1'b0);
      i_Rst = 1'b0;
      for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("midrst_held_count", 32'(o_Count), 32'h00);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("midrst_repress", 32'(o_Count), 32'h01);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("midrst_repress_segs", 32'(o_Segments), 32'h2079);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
